// File: rtl/control_pkg.sv
// Shared configuration for the radix-2 Booth multiplier sequencer:
// operand width, FSM state encoding and Booth pair decode.
package control_pkg;

  // Operand width; also the number of Booth iterations per multiply.
  localparam int N_BIT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  // {Q0, Q-1} pair values that call for an arithmetic step.
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  // Returns {add, sub} for a {Q0, Q-1} pair; 00 and 11 need no arithmetic.
  function automatic logic [1:0] booth_decode(input logic [1:0] pair);
    logic [1:0] r;
    r = 2'b00;
    if (pair == BOOTH_ADD) r = 2'b10;
    if (pair == BOOTH_SUB) r = 2'b01;
    return r;
  endfunction

endpackage

// File: rtl/control_if.sv
// Signal bundle between the Booth sequencer and its datapath/host.
//
// Handshake: Request is a start strobe sampled on the rising clock edge.
// It is accepted only while Done=1 (sequencer idle); while Done=0 it is
// ignored, so a host must treat Done as "ready" and Request as "valid",
// and a start is taken on any edge where both are high.
interface control_if;
  import control_pkg::*;

  logic       Request;   // start strobe
  logic [2:0] Q;         // {unused, Q0, Q-1} from the datapath
  logic       add_s;     // add multiplicand this cycle
  logic       sub_s;     // subtract multiplicand this cycle
  logic       ashift_s;  // arithmetic right shift of {A,Q,Q-1} this cycle
  logic       Done;      // idle / result ready
  state_t     dbg_state; // current FSM state, for observation only

  modport master (
    output Request, Q,
    input  add_s, sub_s, ashift_s, Done, dbg_state
  );

  modport slave (
    input  Request, Q,
    output add_s, sub_s, ashift_s, Done, dbg_state
  );

endinterface

// File: rtl/control.sv
// Booth multiplier sequencer: on a start strobe it spends one cycle in
// LOAD (datapath captures operands), then exactly N_BIT cycles in RUN,
// each issuing a shift plus the add/sub picked by the multiplier LSB pair.
module control #(
  parameter int N_BIT = control_pkg::N_BIT
) (
  input  logic      Clock,
  input  logic      nReset,
  control_if.slave  bus
);
  import control_pkg::*;

  // Wide enough to hold 0..N_BIT.
  localparam int CNT_W = $clog2(N_BIT + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_BIT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       booth_as;

  // Q[2] carries no information for the sequencer.
  logic unused_q2;
  assign unused_q2 = bus.Q[2];

  assign booth_as = booth_decode(bus.Q[1:0]);

  // State and iteration counter; reset aborts any operation at once.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter update and datapath strobes.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bus.Done     = 1'b0;
    bus.ashift_s = 1'b0;
    bus.add_s    = 1'b0;
    bus.sub_s    = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.Done = 1'b1;
        if (bus.Request) state_d = LOAD;
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        bus.ashift_s = 1'b1;
        bus.add_s    = booth_as[1];
        bus.sub_s    = booth_as[0];
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_control.sv
// Directed bench for the Booth sequencer: reset state, completion timing,
// Booth decode during RUN, ignored restarts, mid-run reset, back-to-back
// starts, and a random-Q run checked against a small reference model.
module tb_control;
  import control_pkg::*;

  localparam int NB = 8;

  logic Clock;
  logic nReset;
  logic Request;
  logic [2:0] Q;

  int n_tests;
  int n_fail;

  control_if bus();

  assign bus.Request = Request;
  assign bus.Q       = Q;

  control #(.N_BIT(NB)) dut (
    .Clock  (Clock),
    .nReset (nReset),
    .bus    (bus.slave)
  );

  // Clock: 10 ns period, rising edges at 5, 15, 25 ...
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Hard stop in case something hangs.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  // Wait (bounded) until the sequencer reports idle.
  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (bus.Done !== 1'b1 && k < 40) begin
      @(negedge Clock);
      k++;
    end
    chk(name, 32'(bus.Done), 32'd1);
  endtask

  // Pulse Request for one edge, then observe 20 cycles.
  // Index i is sampled in the cycle after edge k+i (edge k takes the start).
  task automatic run_op(input bit noise, output int first_done,
                        output int busy, output int shifts, output int bad_strobe);
    @(negedge Clock);
    Request = 1'b1;
    @(posedge Clock);
    first_done = -1;
    busy = 0;
    shifts = 0;
    bad_strobe = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (bus.Done === 1'b0) busy++;
      if (bus.ashift_s === 1'b1) shifts++;
      if (bus.Done === 1'b1 && first_done < 0) first_done = i;
      if ((bus.add_s === 1'b1 || bus.sub_s === 1'b1) && bus.ashift_s !== 1'b1) bad_strobe++;
      Request = noise && (i == 3 || i == 8);
    end
    Request = 1'b0;
  endtask

  typedef struct {
    logic [2:0] q;
    logic       add;
    logic       sub;
  } vec_t;

  vec_t vecs[NB];

  initial begin
    int fd, busy, shifts, bad;
    logic done_seen[11];
    int m_state, m_cnt, both_high, model_err;
    logic e_add, e_sub, e_sh, e_done;

    n_tests = 0;
    n_fail  = 0;

    // Booth decode vectors, one per RUN cycle: Q[1:0] selects the op.
    vecs[0] = '{3'b100, 1'b0, 1'b0};
    vecs[1] = '{3'b110, 1'b0, 1'b1};
    vecs[2] = '{3'b011, 1'b0, 1'b0};
    vecs[3] = '{3'b001, 1'b1, 1'b0};
    vecs[4] = '{3'b000, 1'b0, 1'b0};
    vecs[5] = '{3'b101, 1'b1, 1'b0};
    vecs[6] = '{3'b010, 1'b0, 1'b1};
    vecs[7] = '{3'b111, 1'b0, 1'b0};

    // ---- reset, release at 50 ns, check at 200 ns ----
    nReset  = 1'b0;
    Request = 1'b0;
    Q       = 3'b000;
    #1;
    chk("reset_done", 32'(bus.Done), 32'd1);
    #49;
    nReset = 1'b1;
    #150;
    chk("idle_done", 32'(bus.Done), 32'd1);
    chk("idle_add", 32'(bus.add_s), 32'd0);
    chk("idle_sub", 32'(bus.sub_s), 32'd0);
    chk("idle_shift", 32'(bus.ashift_s), 32'd0);
    chk("idle_state", 32'(bus.dbg_state), 32'(IDLE));

    // ---- single operation: timing ----
    run_op(1'b0, fd, busy, shifts, bad);
    chk("op_done_return_idx", 32'(fd), 32'(NB + 1));
    chk("op_busy_cycles", 32'(busy), 32'(NB + 1));
    chk("op_shift_cycles", 32'(shifts), 32'(NB));
    chk("op_strobe_outside_run", 32'(bad), 32'd0);

    // ---- Booth decode table during RUN ----
    @(negedge Clock);
    Request = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Request = 1'b0;
    Q = 3'b001;  // would decode to add, but LOAD must keep strobes low
    #1;
    chk("load_done", 32'(bus.Done), 32'd0);
    chk("load_add", 32'(bus.add_s), 32'd0);
    chk("load_shift", 32'(bus.ashift_s), 32'd0);
    chk("load_state", 32'(bus.dbg_state), 32'(LOAD));
    for (int i = 0; i < NB; i++) begin
      @(negedge Clock);
      Q = vecs[i].q;
      #1;
      chk($sformatf("vec%0d_add", i), 32'(bus.add_s), 32'(vecs[i].add));
      chk($sformatf("vec%0d_sub", i), 32'(bus.sub_s), 32'(vecs[i].sub));
      chk($sformatf("vec%0d_shift", i), 32'(bus.ashift_s), 32'd1);
      chk($sformatf("vec%0d_done", i), 32'(bus.Done), 32'd0);
    end
    @(negedge Clock);
    Q = 3'b010;  // would decode to sub; back in IDLE it must not
    #1;
    chk("after_run_done", 32'(bus.Done), 32'd1);
    chk("after_run_sub", 32'(bus.sub_s), 32'd0);
    chk("after_run_shift", 32'(bus.ashift_s), 32'd0);
    Q = 3'b000;

    // ---- Request pulses during RUN are ignored ----
    run_op(1'b1, fd, busy, shifts, bad);
    chk("noise_done_return_idx", 32'(fd), 32'(NB + 1));
    chk("noise_busy_cycles", 32'(busy), 32'(NB + 1));
    chk("noise_shift_cycles", 32'(shifts), 32'(NB));

    // ---- reset mid-RUN aborts at once ----
    Q = 3'b001;
    @(negedge Clock);
    Request = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Request = 1'b0;
    repeat (4) @(negedge Clock);
    chk("midrun_pre_shift", 32'(bus.ashift_s), 32'd1);
    chk("midrun_pre_add", 32'(bus.add_s), 32'd1);
    #2;
    nReset = 1'b0;
    #1;
    chk("abort_done", 32'(bus.Done), 32'd1);
    chk("abort_add", 32'(bus.add_s), 32'd0);
    chk("abort_shift", 32'(bus.ashift_s), 32'd0);
    chk("abort_state", 32'(bus.dbg_state), 32'(IDLE));
    @(negedge Clock);
    nReset = 1'b1;
    Q = 3'b000;
    run_op(1'b0, fd, busy, shifts, bad);
    chk("post_reset_done_idx", 32'(fd), 32'(NB + 1));
    chk("post_reset_busy", 32'(busy), 32'(NB + 1));
    chk("post_reset_shifts", 32'(shifts), 32'(NB));

    // ---- Request held across completion restarts immediately ----
    @(negedge Clock);
    Request = 1'b1;
    @(posedge Clock);
    for (int i = 0; i < 11; i++) begin
      @(negedge Clock);
      done_seen[i] = bus.Done;
    end
    Request = 1'b0;
    chk("hold_last_run_done", 32'(done_seen[NB]), 32'd0);
    chk("hold_idle_done", 32'(done_seen[NB + 1]), 32'd1);
    chk("hold_restart_done", 32'(done_seen[NB + 2]), 32'd0);
    wait_idle("hold_final_idle");

    // ---- random Q / Request against a reference model ----
    @(negedge Clock);
    m_state   = 0;
    m_cnt     = 0;
    both_high = 0;
    model_err = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge Clock);
      Request = ($urandom_range(0, 9) == 0);
      Q = 3'($urandom_range(0, 7));
      #1;
      e_done = (m_state == 0);
      e_sh   = (m_state == 2);
      e_add  = (m_state == 2) && (Q[1:0] == 2'b01);
      e_sub  = (m_state == 2) && (Q[1:0] == 2'b10);
      if (bus.add_s === 1'b1 && bus.sub_s === 1'b1) both_high++;
      if (bus.Done !== e_done || bus.ashift_s !== e_sh ||
          bus.add_s !== e_add || bus.sub_s !== e_sub) begin
        model_err++;
        if (model_err <= 5)
          $display("rand cycle %0d: done=%b sh=%b add=%b sub=%b, model %b %b %b %b",
                   c, bus.Done, bus.ashift_s, bus.add_s, bus.sub_s,
                   e_done, e_sh, e_add, e_sub);
      end
      @(posedge Clock);
      case (m_state)
        0: if (Request) m_state = 1;
        1: begin m_state = 2; m_cnt = 0; end
        default: begin
          if (m_cnt == NB - 1) m_state = 0;
          m_cnt++;
        end
      endcase
    end
    Request = 1'b0;
    chk("rand_add_sub_both_high", 32'(both_high), 32'd0);
    chk("rand_model_mismatches", 32'(model_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
